// File: rtl/fifo_skew_reader_pkg.sv
// Shared types and defaults for the north-edge FIFO skew reader.
package fifo_skew_reader_pkg;

    // Default geometry of the MAC array top row.
    localparam int unsigned DEF_MAC_WIDTH = 256;
    localparam int unsigned DEF_DATA_SIZE = 8;
    localparam int unsigned DEF_MAX_TILE  = 256;
    localparam int unsigned STALL_CNT_W   = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Saturating increment for the stall counter.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (v == {STALL_CNT_W{1'b1}}) ? v : v + STALL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/fifo_skew_reader_if.sv
// Control, FIFO-side and MAC-side signals of the skew reader.
interface fifo_skew_reader_if
    import fifo_skew_reader_pkg::*;
#(
    parameter int unsigned MAC_WIDTH = DEF_MAC_WIDTH,
    parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
    parameter int unsigned MAX_TILE  = DEF_MAX_TILE
);
    localparam int unsigned LEN_W = $clog2(MAX_TILE + 1);

    logic                           start;
    logic [LEN_W-1:0]               tile_len;
    logic [MAC_WIDTH*DATA_SIZE-1:0] fifo_dout;
    logic [MAC_WIDTH-1:0]           fifo_empty;
    logic [MAC_WIDTH-1:0]           fifo_rd_en;
    logic [MAC_WIDTH*DATA_SIZE-1:0] mac_data;
    logic [MAC_WIDTH-1:0]           mac_valid;
    logic                           busy;
    logic                           done;
    logic [STALL_CNT_W-1:0]         stall_cnt;

    // Environment side: tile control and the FIFO bank.
    modport master (
        output start, tile_len, fifo_dout, fifo_empty,
        input  fifo_rd_en, mac_data, mac_valid, busy, done, stall_cnt
    );

    // Reader side.
    modport slave (
        input  start, tile_len, fifo_dout, fifo_empty,
        output fifo_rd_en, mac_data, mac_valid, busy, done, stall_cnt
    );

endinterface

// File: rtl/fifo_skew_reader_lane.sv
// One lane of the skew reader: window compare, read strobe and output register.
module fifo_skew_reader_lane #(
    parameter int unsigned LANE      = 0,
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned T_W       = 9,
    parameter int unsigned LEN_W     = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 stall,
    input  logic [T_W-1:0]       t,
    input  logic [LEN_W-1:0]     tile_len,
    input  logic [DATA_SIZE-1:0] dout,
    output logic                 in_window,
    output logic                 rd_en,
    output logic                 mac_valid,
    output logic [DATA_SIZE-1:0] mac_data
);
    // One extra bit so LANE + tile_len never wraps.
    localparam int unsigned CW = ((T_W > LEN_W) ? T_W : LEN_W) + 1;
    localparam logic [CW-1:0] LANE_IDX = CW'(LANE);

    logic [CW-1:0] t_ext;
    logic [CW-1:0] win_end;

    // Lane is active for steps LANE .. LANE+tile_len-1.
    always_comb begin
        t_ext     = CW'(t);
        win_end   = LANE_IDX + CW'(tile_len);
        in_window = run && (t_ext >= LANE_IDX) && (t_ext < win_end);
        rd_en     = in_window && !stall;
    end

    // FIFO data arrives one cycle after the strobe, so valid is the strobe delayed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mac_valid <= 1'b0;
        end else begin
            mac_valid <= rd_en;
        end
    end

    // Bubbles are forced to zero so the array never sees stale FIFO output.
    always_comb begin
        mac_data = mac_valid ? dout : '0;
    end

endmodule

// File: rtl/fifo_skew_reader.sv
// Diagonal-wavefront reader for the north-edge FIFO bank.
module fifo_skew_reader
    import fifo_skew_reader_pkg::*;
#(
    parameter int unsigned MAC_WIDTH = DEF_MAC_WIDTH,
    parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
    parameter int unsigned MAX_TILE  = DEF_MAX_TILE
) (
    input  logic               clk,
    input  logic               reset,
    fifo_skew_reader_if.slave  bus
);
    localparam int unsigned LEN_W = $clog2(MAX_TILE + 1);
    localparam int unsigned T_W   = $clog2(MAX_TILE + MAC_WIDTH);
    localparam int unsigned CW    = ((T_W > LEN_W) ? T_W : LEN_W) + 1;

    state_e                 state_q, state_d;
    logic [T_W-1:0]         t_q, t_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic                   run;
    logic                   stall;
    logic                   last_step;
    logic [CW-1:0]          t_last;
    logic [MAC_WIDTH-1:0]   window;
    logic [MAC_WIDTH-1:0]   rd_en;
    logic [MAC_WIDTH-1:0]   valid;
    logic [MAC_WIDTH*DATA_SIZE-1:0] data;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A zero-length tile skips RUN but still passes through
    // DRAIN, so busy spans two cycles with no reads.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = (bus.tile_len == '0) ? StDrain : StRun;
                end
            end
            StRun: begin
                if (!stall && last_step) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        run      = (state_q == StRun);
        bus.busy = (state_q != StIdle);
        bus.done = (state_q == StDone);
    end

    // Last wavefront step: lane MAC_WIDTH-1 reads its final entry.
    always_comb begin
        t_last    = CW'(len_q) + CW'(MAC_WIDTH) - CW'(2);
        last_step = (CW'(t_q) == t_last);
        stall     = run && |(window & bus.fifo_empty);
    end

    // Step counter, latched length and stall counter next-state.
    always_comb begin
        t_d         = t_q;
        len_d       = len_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == StIdle) begin
            if (bus.start) begin
                t_d         = '0;
                len_d       = bus.tile_len;
                stall_cnt_d = '0;
            end
        end else if (run) begin
            // Holding t on a stall keeps every lane's offset intact.
            if (stall) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end else if (!last_step) begin
                t_d = t_q + T_W'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_q         <= '0;
            len_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            t_q         <= t_d;
            len_q       <= len_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    for (genvar i = 0; i < MAC_WIDTH; i++) begin : g_lane
        fifo_skew_reader_lane #(
            .LANE      (i),
            .DATA_SIZE (DATA_SIZE),
            .T_W       (T_W),
            .LEN_W     (LEN_W)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .run       (run),
            .stall     (stall),
            .t         (t_q),
            .tile_len  (len_q),
            .dout      (bus.fifo_dout[i*DATA_SIZE +: DATA_SIZE]),
            .in_window (window[i]),
            .rd_en     (rd_en[i]),
            .mac_valid (valid[i]),
            .mac_data  (data[i*DATA_SIZE +: DATA_SIZE])
        );
    end

    // Drive the interface outputs.
    always_comb begin
        bus.fifo_rd_en = rd_en;
        bus.mac_valid  = valid;
        bus.mac_data   = data;
        bus.stall_cnt  = stall_cnt_q;
    end

endmodule

// File: tb/tb_fifo_skew_reader.sv
// Directed bench for fifo_skew_reader with a 4-lane FIFO bank model.
module tb_fifo_skew_reader;
    localparam int W = 4;
    localparam int D = 8;

    logic clk = 1'b0;
    logic reset;

    fifo_skew_reader_if #(.MAC_WIDTH(W), .DATA_SIZE(D), .MAX_TILE(256)) bus ();

    fifo_skew_reader #(.MAC_WIDTH(W), .DATA_SIZE(D), .MAX_TILE(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // FIFO bank model: 1-cycle read latency, never reset by the DUT reset.
    logic [7:0] mem [W][64];
    logic [7:0] dout [W];
    int wr_ptr [W] = '{default: 0};
    int rd_ptr [W] = '{default: 0};
    int rd_empty_errs = 0;
    int base_ptr [W];

    always @(posedge clk) begin
        for (int i = 0; i < W; i++) begin
            if (bus.fifo_rd_en[i]) begin
                if (wr_ptr[i] == rd_ptr[i]) begin
                    rd_empty_errs <= rd_empty_errs + 1;
                end else begin
                    dout[i]   <= mem[i][rd_ptr[i]];
                    rd_ptr[i] <= rd_ptr[i] + 1;
                end
            end
        end
    end

    always_comb begin
        bus.fifo_dout  = '0;
        bus.fifo_empty = '0;
        for (int i = 0; i < W; i++) begin
            bus.fifo_dout[i*D +: D] = dout[i];
            bus.fifo_empty[i]       = (wr_ptr[i] == rd_ptr[i]);
        end
    end

    task automatic push(input int lane, input int n);
        for (int k = 0; k < n; k++) begin
            mem[lane][wr_ptr[lane]] = 8'(8'h10 * lane + k);
            wr_ptr[lane] = wr_ptr[lane] + 1;
        end
    endtask

    // Recorded trace, indexed by cycle after start (start cycle = 0).
    logic [W-1:0]   exp_rd   [0:47];
    logic [W-1:0]   rec_rd   [0:47];
    logic [W-1:0]   rec_val  [0:47];
    logic [W*D-1:0] rec_data [0:47];
    logic           rec_busy [0:47];
    int done_cyc;

    task automatic clear_exp();
        for (int c = 0; c < 48; c++) exp_rd[c] = '0;
    endtask

    // Unstalled tile_len=3 wavefront.
    task automatic load_exp_basic();
        clear_exp();
        exp_rd[1] = 4'b0001; exp_rd[2] = 4'b0011; exp_rd[3] = 4'b0111;
        exp_rd[4] = 4'b1110; exp_rd[5] = 4'b1100; exp_rd[6] = 4'b1000;
    endtask

    // Expected mac_data at cycle c from the expected read table and FIFO contents.
    function automatic logic [W*D-1:0] exp_mac(input int c);
        logic [W*D-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            int n;
            n = 0;
            for (int k = 1; k < c - 1; k++) if (exp_rd[k][i]) n++;
            if (c >= 1 && exp_rd[c-1][i]) r[i*D +: D] = mem[i][base_ptr[i] + n];
        end
        return r;
    endfunction

    // Start a tile and record outputs each cycle until done or the cycle budget runs out.
    task automatic run_tile(input int len, input int late_at, input int late_lane,
                            input int late_n, input int repulse_at);
        @(negedge clk);
        for (int i = 0; i < W; i++) base_ptr[i] = rd_ptr[i];
        bus.start    = 1'b1;
        bus.tile_len = 9'(len);
        done_cyc     = -1;
        for (int c = 1; c < 40; c++) begin
            @(posedge clk);
            #1;
            bus.start = (c == repulse_at);
            if (c == repulse_at) bus.tile_len = 9'd2;
            if (c == late_at) push(late_lane, late_n);
            @(negedge clk);
            rec_rd[c]   = bus.fifo_rd_en;
            rec_val[c]  = bus.mac_valid;
            rec_data[c] = bus.mac_data;
            rec_busy[c] = bus.busy;
            if (bus.done) begin
                done_cyc = c;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.tile_len = '0;
        for (int i = 0; i < W; i++) dout[i] = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.fifo_rd_en, bus.mac_valid, bus.mac_data, bus.busy, bus.done, bus.stall_cnt} !== '0)
        begin
            errors++;
            $display("FAIL reset_outputs: rd=%b val=%b data=%h busy=%b done=%b stall=%0d, want all 0",
                     bus.fifo_rd_en, bus.mac_valid, bus.mac_data, bus.busy, bus.done,
                     bus.stall_cnt);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < W; i++) push(i, 3);
        load_exp_basic();
        run_tile(3, -1, 0, 0, -1);
        checks++;
        if (done_cyc !== 8) begin
            errors++;
            $display("FAIL basic_done_cycle: got %0d want 8", done_cyc);
        end
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (rec_rd[c] !== exp_rd[c] || rec_val[c] !== exp_rd[c-1] ||
                rec_data[c] !== exp_mac(c) || rec_busy[c] !== 1'b1) begin
                errors++;
                $display("FAIL basic_cycle%0d: rd=%b val=%b data=%h busy=%b want rd=%b val=%b data=%h busy=1",
                         c, rec_rd[c], rec_val[c], rec_data[c], rec_busy[c], exp_rd[c],
                         exp_rd[c-1], exp_mac(c));
            end
        end
        checks++;
        if (rec_data[5][31:24] !== 8'h30 || rec_data[6][31:24] !== 8'h31 ||
            rec_data[7][31:24] !== 8'h32) begin
            errors++;
            $display("FAIL basic_lane3_data: %h %h %h want 30 31 32",
                     rec_data[5][31:24], rec_data[6][31:24], rec_data[7][31:24]);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL basic_after: busy=%b done=%b stall=%0d want 0 0 0",
                     bus.busy, bus.done, bus.stall_cnt);
        end
    endtask

    task automatic test_stall();
        push(0, 3); push(1, 3); push(2, 1); push(3, 3);
        clear_exp();
        exp_rd[1] = 4'b0001; exp_rd[2] = 4'b0011; exp_rd[3] = 4'b0111;
        exp_rd[6] = 4'b1110; exp_rd[7] = 4'b1100; exp_rd[8] = 4'b1000;
        run_tile(3, 6, 2, 2, -1);
        checks++;
        if (done_cyc !== 10) begin
            errors++;
            $display("FAIL stall_done_cycle: got %0d want 10", done_cyc);
        end
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (rec_rd[c] !== exp_rd[c] || rec_val[c] !== exp_rd[c-1] ||
                rec_data[c] !== exp_mac(c)) begin
                errors++;
                $display("FAIL stall_cycle%0d: rd=%b val=%b data=%h want rd=%b val=%b data=%h",
                         c, rec_rd[c], rec_val[c], rec_data[c], exp_rd[c], exp_rd[c-1],
                         exp_mac(c));
            end
        end
        checks++;
        if (bus.stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL stall_count: got %0d want 2", bus.stall_cnt);
        end
    endtask

    task automatic test_zero_len();
        int rd_seen;
        rd_seen = 0;
        clear_exp();
        run_tile(0, -1, 0, 0, -1);
        for (int c = 1; c <= 2; c++) if (rec_rd[c] != '0) rd_seen++;
        checks++;
        if (done_cyc !== 2 || rec_busy[1] !== 1'b1 || rd_seen !== 0) begin
            errors++;
            $display("FAIL zero_len: done_cyc=%0d busy1=%b reads=%0d want 2 1 0",
                     done_cyc, rec_busy[1], rd_seen);
        end
        checks++;
        if (bus.stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL zero_len_stall_clear: got %0d want 0", bus.stall_cnt);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_idle: busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_restart_ignored();
        int cnt [W];
        for (int i = 0; i < W; i++) begin
            push(i, 3);
            cnt[i] = 0;
        end
        load_exp_basic();
        run_tile(3, -1, 0, 0, 3);
        for (int c = 1; c <= 8; c++)
            for (int i = 0; i < W; i++) if (rec_rd[c][i]) cnt[i]++;
        checks++;
        if (done_cyc !== 8) begin
            errors++;
            $display("FAIL restart_done_cycle: got %0d want 8", done_cyc);
        end
        for (int i = 0; i < W; i++) begin
            checks++;
            if (cnt[i] !== 3) begin
                errors++;
                $display("FAIL restart_reads_lane%0d: got %0d want 3", i, cnt[i]);
            end
        end
    endtask

    task automatic test_outside_window_empty();
        push(0, 3); push(1, 3); push(2, 3);
        load_exp_basic();
        run_tile(3, 4, 3, 3, -1);
        checks++;
        if (done_cyc !== 8 || bus.stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL outside_window: done_cyc=%0d stall=%0d want 8 0",
                     done_cyc, bus.stall_cnt);
        end
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (rec_rd[c] !== exp_rd[c] || rec_data[c] !== exp_mac(c)) begin
                errors++;
                $display("FAIL outside_window_cycle%0d: rd=%b data=%h want rd=%b data=%h",
                         c, rec_rd[c], rec_data[c], exp_rd[c], exp_mac(c));
            end
        end
    endtask

    task automatic test_reset_mid_tile();
        for (int i = 0; i < W; i++) push(i, 3);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.tile_len = 9'd3;
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.fifo_rd_en, bus.mac_valid, bus.mac_data, bus.busy, bus.done, bus.stall_cnt} !== '0)
        begin
            errors++;
            $display("FAIL reset_mid_tile: rd=%b val=%b data=%h busy=%b done=%b want all 0",
                     bus.fifo_rd_en, bus.mac_valid, bus.mac_data, bus.busy, bus.done);
        end
        @(negedge clk);
        reset = 1'b0;
        clear_exp();
        exp_rd[1] = 4'b0001; exp_rd[2] = 4'b0010; exp_rd[3] = 4'b0100; exp_rd[4] = 4'b1000;
        run_tile(1, -1, 0, 0, -1);
        checks++;
        if (done_cyc !== 6) begin
            errors++;
            $display("FAIL after_reset_done_cycle: got %0d want 6", done_cyc);
        end
        checks++;
        if (rec_data[2][7:0] !== 8'h02 || rec_data[3][15:8] !== 8'h11 ||
            rec_data[4][23:16] !== 8'h20 || rec_data[5][31:24] !== 8'h30) begin
            errors++;
            $display("FAIL after_reset_data: %h %h %h %h want 02 11 20 30", rec_data[2][7:0],
                     rec_data[3][15:8], rec_data[4][23:16], rec_data[5][31:24]);
        end
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (rec_rd[c] !== exp_rd[c] || rec_val[c] !== exp_rd[c-1]) begin
                errors++;
                $display("FAIL after_reset_cycle%0d: rd=%b val=%b want rd=%b val=%b",
                         c, rec_rd[c], rec_val[c], exp_rd[c], exp_rd[c-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_restart_ignored();
        test_outside_window_empty();
        test_reset_mid_tile();
        checks++;
        if (rd_empty_errs !== 0) begin
            errors++;
            $display("FAIL read_on_empty: got %0d reads of an empty lane want 0", rd_empty_errs);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
